// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: byte-enabled stores, fixed-latency loads, and a
// zero-fill sweep of the whole array after every reset.
`timescale 1ns/1ps
module data_sram_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned READ_LAT  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h1c800000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_ready,
  output logic [31:0] data_sram_rdata,
  output logic        rdata_valid,
  output logic        addr_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              ready_q, ready_d;

  logic [31:0] mem [DEPTH];

  logic [READ_LAT-1:0] vld_q, vld_d;
  logic [READ_LAT-1:0] err_q, err_d;
  logic [31:0]         data_q [READ_LAT];
  logic [31:0]         data_d [READ_LAT];

  logic              accept;
  logic              in_range;
  logic              is_load;
  logic              store_hit;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       head_data;
  logic [1:0]        unused_addr_lo;

  assign unused_addr_lo = data_sram_addr[1:0];

  assign accept    = data_sram_en && ready_q;
  assign in_range  = (data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign word_idx  = data_sram_addr[ADDR_W+1:2];
  assign is_load   = (data_sram_we == 4'b0000);
  assign store_hit = accept && !is_load && in_range;
  assign head_data = in_range ? mem[word_idx] : 32'h0;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    case (state_q)
      ST_INIT: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_IDLE: ready_d = 1'b1;
      default: state_d = ST_INIT;
    endcase
  end

  // Data in each stage only advances behind a valid load, so the last stage
  // keeps presenting the most recent load data between responses.
  always_comb begin
    vld_d = '0;
    err_d = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      data_d[i] = data_q[i];
    end
    vld_d[0] = accept && is_load;
    err_d[0] = accept && !in_range;
    if (accept && is_load) begin
      data_d[0] = head_data;
    end
    for (int i = 1; i < READ_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      err_d[i] = err_q[i-1];
      if (vld_q[i-1]) begin
        data_d[i] = data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_INIT;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
      vld_q     <= '0;
      err_q     <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        data_q[i] <= 32'h0;
      end
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      for (int i = 0; i < READ_LAT; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // The array has no reset; the INIT sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[clr_ptr_q] <= 32'h0;
    end else if (store_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_we[b]) begin
          mem[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  assign data_sram_ready = ready_q;
  assign rdata_valid     = vld_q[READ_LAT-1];
  assign addr_err        = err_q[READ_LAT-1];
  assign data_sram_rdata = data_q[READ_LAT-1];

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder at READ_LAT=3: random and directed traffic
// compared cycle by cycle against a transaction-level memory/response model.
`timescale 1ns/1ps
module tb_data_sram_responder;

  localparam int          ADDR_W = 10;
  localparam int          LAT    = 3;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] BASE   = 32'h1c800000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready;
  logic        rvalid;
  logic        aerr;
  logic [31:0] rdata;

  int passCount = 0;
  int checkCount = 0;

  typedef struct {
    int          due;
    bit          vld;
    bit          err;
    logic [31:0] data;
  } resp_t;

  resp_t       pend[$];
  logic [31:0] refMem [DEPTH];
  bit          refReady = 1'b0;
  int          initCnt = 0;
  int          cyc = 0;
  logic [31:0] refRdata = 32'h0;
  logic [34:0] expOut;

  data_sram_responder #(
    .ADDR_W   (ADDR_W),
    .READ_LAT (LAT),
    .BASE_ADDR(BASE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_sram_en   (en),
    .data_sram_we   (we),
    .data_sram_addr (addr),
    .data_sram_wdata(wdata),
    .data_sram_ready(ready),
    .data_sram_rdata(rdata),
    .rdata_valid    (rvalid),
    .addr_err       (aerr)
  );

  always #5 clk = ~clk;

  // Whatever was in flight is lost and the zero-fill starts over.
  task automatic clearModel;
    pend.delete();
    refRdata = 32'h0;
    refReady = 1'b0;
    initCnt  = 0;
  endtask

  task automatic applyReset(input int hold);
    en = 1'b0;
    reset = 1'b1;
    #1;
    clearModel();
    repeat (hold) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Drives one cycle of request, advances the model at the edge and leaves
  // the expected {ready, valid, err, rdata} for the cycle that follows.
  task automatic applyStimulus(input bit e, input logic [3:0] w,
                               input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    int          idx;
    resp_t       r;
    bit          vld;
    bit          err;
    en = e; we = w; addr = a; wdata = d;
    @(posedge clk);
    cyc++;
    if (e && refReady) begin
      off = a - BASE;
      idx = int'(off >> 2);
      r.due = cyc + LAT - 1;
      if (w == 4'h0) begin
        r.vld  = 1'b1;
        r.err  = !(off < 32'(DEPTH * 4));
        r.data = r.err ? 32'h0 : refMem[idx];
        pend.push_back(r);
      end else if (!(off < 32'(DEPTH * 4))) begin
        r.vld  = 1'b0;
        r.err  = 1'b1;
        r.data = 32'h0;
        pend.push_back(r);
      end else begin
        for (int b = 0; b < 4; b++)
          if (w[b]) refMem[idx][8*b +: 8] = d[8*b +: 8];
      end
    end
    if (!refReady) begin
      initCnt++;
      if (initCnt == DEPTH) begin
        refReady = 1'b1;
        foreach (refMem[i]) refMem[i] = 32'h0;
      end
    end
    #1;
    vld = 1'b0;
    err = 1'b0;
    while (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      vld |= r.vld;
      err |= r.err;
      if (r.vld) refRdata = r.data;
    end
    expOut = {refReady, vld, err, refRdata};
    en = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    reset = 1'b1;
    #1;
    clearModel();
    checkCount++;
    if ({ready, rvalid, aerr, rdata} !== 35'h0)
      $display("[TB] FAIL reset_async: got %h expected %h", {ready, rvalid, aerr, rdata}, 35'h0);
    else passCount++;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkCount++;
    if ({ready, rvalid, aerr, rdata} !== 35'h0)
      $display("[TB] FAIL reset_release: got %h expected %h", {ready, rvalid, aerr, rdata}, 35'h0);
    else passCount++;
  endtask

  task automatic test_init;
    for (int i = 0; i < DEPTH + 4; i++) begin
      applyStimulus((i < DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0, 4'($urandom_range(0, 15)),
                    BASE + 32'($urandom_range(0, DEPTH - 1) << 2), $urandom);
      checkCount++;
      if ({ready, rvalid, aerr, rdata} !== expOut)
        $display("[TB] FAIL init_cycle%0d: got %h expected %h", i, {ready, rvalid, aerr, rdata}, expOut);
      else passCount++;
    end
    for (int i = 0; i < DEPTH + LAT; i++) begin
      applyStimulus(i < DEPTH, 4'h0, BASE + 32'(i << 2), 32'h0);
      checkCount++;
      if ({ready, rvalid, aerr, rdata} !== expOut)
        $display("[TB] FAIL init_zero_load%0d: got %h expected %h", i, {ready, rvalid, aerr, rdata}, expOut);
      else passCount++;
    end
  endtask

  task automatic test_byte_store;
    logic [31:0] a;
    logic [3:0]  w;
    applyStimulus(1'b1, 4'hf, 32'h1c800010, 32'hdeadbeef);
    applyStimulus(1'b1, 4'h1, 32'h1c800010, 32'h000000aa);
    applyStimulus(1'b1, 4'h0, 32'h1c800010, 32'h0);
    repeat (LAT - 1) applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    checkCount++;
    if ({rvalid, aerr, rdata} !== {1'b1, 1'b0, 32'hdeadbeaa})
      $display("[TB] FAIL byte_merge: got %h expected %h", {rvalid, aerr, rdata}, {1'b1, 1'b0, 32'hdeadbeaa});
    else passCount++;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = BASE + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
      w = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      applyStimulus($urandom_range(0, 3) != 0, w, a, $urandom);
      checkCount++;
      if ({ready, rvalid, aerr, rdata} !== expOut)
        $display("[TB] FAIL random_mix%0d: got %h expected %h", i, {ready, rvalid, aerr, rdata}, expOut);
      else passCount++;
    end
    repeat (LAT) applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 4'hf, BASE + 32'(i << 2), 32'h11110000 + 32'(i));
    for (int i = 0; i < 3 + LAT; i++) begin
      applyStimulus(i < 3, 4'h0, BASE + 32'(i << 2), 32'h0);
      checkCount++;
      if ({ready, rvalid, aerr, rdata} !== expOut)
        $display("[TB] FAIL back_to_back%0d: got %h expected %h", i, {ready, rvalid, aerr, rdata}, expOut);
      else passCount++;
    end
  endtask

  task automatic test_out_of_range;
    applyStimulus(1'b1, 4'h0, 32'h1c000000, 32'h0);
    repeat (LAT - 1) applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    checkCount++;
    if ({rvalid, aerr, rdata} !== {1'b1, 1'b1, 32'h0})
      $display("[TB] FAIL oor_load: got %h expected %h", {rvalid, aerr, rdata}, {1'b1, 1'b1, 32'h0});
    else passCount++;
    for (int i = 0; i < 2 * LAT + 2; i++) begin
      if (i == 0) applyStimulus(1'b1, 4'hf, 32'h00000000, 32'hcafef00d);
      else if (i == 1) applyStimulus(1'b1, 4'h0, BASE, 32'h0);
      else applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      checkCount++;
      if ({ready, rvalid, aerr, rdata} !== expOut)
        $display("[TB] FAIL oor_store%0d: got %h expected %h", i, {ready, rvalid, aerr, rdata}, expOut);
      else passCount++;
    end
  endtask

  task automatic test_ordering;
    for (int i = 0; i < 4 + 2 * LAT; i++) begin
      case (i)
        0: applyStimulus(1'b1, 4'hf, BASE + 32'd20, 32'h12345678);
        1: applyStimulus(1'b1, 4'h0, BASE + 32'd20, 32'h0);
        LAT + 2: applyStimulus(1'b1, 4'h0, BASE + 32'd20, 32'h0);
        LAT + 3: applyStimulus(1'b1, 4'hf, BASE + 32'd20, 32'h0);
        default: applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      endcase
      checkCount++;
      if ({ready, rvalid, aerr, rdata} !== expOut)
        $display("[TB] FAIL ordering%0d: got %h expected %h", i, {ready, rvalid, aerr, rdata}, expOut);
      else passCount++;
    end
  endtask

  task automatic test_reset_in_flight;
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 4'hf, BASE + 32'(i << 2), $urandom | 32'h1);
    applyReset(1);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 4'h0, BASE, 32'h0);
      checkCount++;
      if ({ready, rvalid, aerr, rdata} !== expOut)
        $display("[TB] FAIL mid_init%0d: got %h expected %h", i, {ready, rvalid, aerr, rdata}, expOut);
      else passCount++;
    end
    applyReset(2);
    for (int i = 0; i < DEPTH + 2; i++) begin
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      checkCount++;
      if ({ready, rvalid, aerr, rdata} !== expOut)
        $display("[TB] FAIL restart_sweep%0d: got %h expected %h", i, {ready, rvalid, aerr, rdata}, expOut);
      else passCount++;
    end
    applyStimulus(1'b1, 4'hf, BASE + 32'd12, 32'h5a5a5a5a);
    applyStimulus(1'b1, 4'h0, BASE + 32'd12, 32'h0);
    reset = 1'b1;
    #1;
    clearModel();
    checkCount++;
    if ({ready, rvalid, aerr, rdata} !== 35'h0)
      $display("[TB] FAIL flight_reset_async: got %h expected %h", {ready, rvalid, aerr, rdata}, 35'h0);
    else passCount++;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < DEPTH + 8 + LAT; i++) begin
      if (i >= DEPTH + 1 && i < DEPTH + 9) applyStimulus(1'b1, 4'h0, BASE + 32'((i - DEPTH - 1) << 2), 32'h0);
      else applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      checkCount++;
      if ({ready, rvalid, aerr, rdata} !== expOut)
        $display("[TB] FAIL after_flight%0d: got %h expected %h", i, {ready, rvalid, aerr, rdata}, expOut);
      else passCount++;
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_byte_store();
    test_back_to_back();
    test_out_of_range();
    test_ordering();
    test_reset_in_flight();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
